// File: rtl/uart_cmd_responder_if.sv
`timescale 1ns/1ps
// Link between the command responder and its UART receiver/transmitter and register bus.
// The master side is the responder; the slave side is the surrounding UART and register file.
interface uart_cmd_responder_if;
  logic [7:0] ipRxData;
  logic       ipRxValid;
  logic [7:0] opTxData;
  logic       opTxSend;
  logic       ipTxBusy;
  logic [7:0] opAddr;
  logic [7:0] opWrData;
  logic       opWrEnable;
  logic [7:0] ipRdData;

  modport master (
    input  ipRxData, ipRxValid, ipTxBusy, ipRdData,
    output opTxData, opTxSend, opAddr, opWrData, opWrEnable
  );

  modport slave (
    output ipRxData, ipRxValid, ipTxBusy, ipRdData,
    input  opTxData, opTxSend, opAddr, opWrData, opWrEnable
  );
endinterface

// File: rtl/uart_cmd_responder.sv
`timescale 1ns/1ps
// Parses SYNC/CMD/ADDR/DATA packets from a UART into register bus accesses and answers with one byte.
// Define CHECKSUM_EN to require a trailing CHK byte (CMD ^ ADDR ^ DATA).
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                  ipClk,
  input logic                  ipReset,
  uart_cmd_responder_if.master bus
);
  localparam int unsigned ByteW = 8;
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ByteW-1:0] SyncByte = 8'h55;
  localparam logic [ByteW-1:0] CmdWrite = 8'h01;
  localparam logic [ByteW-1:0] CmdRead  = 8'h02;
  localparam logic [ByteW-1:0] AckByte  = 8'h06;
  localparam logic [ByteW-1:0] NakByte  = 8'h15;

  typedef enum logic [3:0] {
    Idle, Cmd, Addr, Data, Check, Exec, RdWait, TxWaitIdle, TxAssert, TxRelease
  } stateT;

  stateT            state, stateNext;
  logic [CntW-1:0]  gapCount;
  logic [ByteW-1:0] cmdByte, addrByte, dataByte;
  logic [ByteW-1:0] cmdCur, addrCur, dataCur;
  logic             inPacket, timeoutHit, rxAccept, chkOk, cmdValid;
  logic [ByteW-1:0] txDataReg, addrReg, wrDataReg;
  logic [ByteW-1:0] txDataNext, addrNext, wrDataNext;
  logic             txSendReg, wrEnableReg, txSendNext, wrEnableNext;

  assign inPacket   = (state == Cmd) || (state == Addr) || (state == Data) || (state == Check);
  assign timeoutHit = inPacket && (gapCount == CntW'(TIMEOUT_CYCLES - 1));
  assign rxAccept   = bus.ipRxValid && !timeoutHit;

  // Captured bytes including the one arriving this cycle, so Exec-entry outputs can register directly
  assign cmdCur  = (state == Cmd  && rxAccept) ? bus.ipRxData : cmdByte;
  assign addrCur = (state == Addr && rxAccept) ? bus.ipRxData : addrByte;
  assign dataCur = (state == Data && rxAccept) ? bus.ipRxData : dataByte;

`ifdef CHECKSUM_EN
  logic [ByteW-1:0] chkByte, chkCur;
  assign chkCur = (state == Check && rxAccept) ? bus.ipRxData : chkByte;
  assign chkOk  = (chkCur == (cmdCur ^ addrCur ^ dataCur));
`else
  assign chkOk  = 1'b1;
`endif

  assign cmdValid = chkOk && ((cmdCur == CmdWrite) || (cmdCur == CmdRead));

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) state <= Idle;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      Idle:       if (bus.ipRxValid && bus.ipRxData == SyncByte) stateNext = Cmd;
      Cmd:        if (timeoutHit) stateNext = Idle; else if (rxAccept) stateNext = Addr;
      Addr:       if (timeoutHit) stateNext = Idle; else if (rxAccept) stateNext = Data;
`ifdef CHECKSUM_EN
      Data:       if (timeoutHit) stateNext = Idle; else if (rxAccept) stateNext = Check;
`else
      Data:       if (timeoutHit) stateNext = Idle; else if (rxAccept) stateNext = Exec;
`endif
      Check:      if (timeoutHit) stateNext = Idle; else if (rxAccept) stateNext = Exec;
      Exec:       stateNext = (cmdValid && cmdCur == CmdRead) ? RdWait : TxWaitIdle;
      RdWait:     stateNext = TxWaitIdle;
      TxWaitIdle: if (!bus.ipTxBusy) stateNext = TxAssert;
      TxAssert:   if (bus.ipTxBusy) stateNext = TxRelease;
      TxRelease:  stateNext = Idle;
      default:    stateNext = Idle;
    endcase
  end

  // Next values of the registered outputs, keyed on the state being entered
  always_comb begin
    txDataNext   = txDataReg;
    addrNext     = addrReg;
    wrDataNext   = wrDataReg;
    wrEnableNext = 1'b0;
    txSendNext   = (stateNext == TxAssert);
    if (stateNext == Exec && cmdValid) addrNext = addrCur;
    if (stateNext == Exec && cmdValid && cmdCur == CmdWrite) begin
      wrEnableNext = 1'b1;
      wrDataNext   = dataCur;
    end
    if (state == Exec && stateNext == TxWaitIdle) txDataNext = cmdValid ? AckByte : NakByte;
    if (state == RdWait) txDataNext = bus.ipRdData;
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      gapCount    <= '0;
      cmdByte     <= '0;
      addrByte    <= '0;
      dataByte    <= '0;
`ifdef CHECKSUM_EN
      chkByte     <= '0;
`endif
      txDataReg   <= '0;
      addrReg     <= '0;
      wrDataReg   <= '0;
      txSendReg   <= 1'b0;
      wrEnableReg <= 1'b0;
    end else begin
      gapCount    <= (bus.ipRxValid || !inPacket) ? '0 : gapCount + CntW'(1);
      cmdByte     <= cmdCur;
      addrByte    <= addrCur;
      dataByte    <= dataCur;
`ifdef CHECKSUM_EN
      chkByte     <= chkCur;
`endif
      txDataReg   <= txDataNext;
      addrReg     <= addrNext;
      wrDataReg   <= wrDataNext;
      txSendReg   <= txSendNext;
      wrEnableReg <= wrEnableNext;
    end
  end

  assign bus.opTxData   = txDataReg;
  assign bus.opTxSend   = txSendReg;
  assign bus.opAddr     = addrReg;
  assign bus.opWrData   = wrDataReg;
  assign bus.opWrEnable = wrEnableReg;
endmodule

// File: tb/tb_uart_cmd_responder.sv
`timescale 1ns/1ps
// Directed bench for uart_cmd_responder: write/read/NAK packets, timeout, TX handshake and reset.
// Builds with or without CHECKSUM_EN; the packet length follows the macro.
module tb_uart_cmd_responder;
  localparam int unsigned TimeoutCycles = 40;
`ifdef CHECKSUM_EN
  localparam int PktLen = 5;
`else
  localparam int PktLen = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic autoTx = 1'b1;
  logic manualBusy = 1'b0;
  int   modelBusyCnt = 0;

  int   errors = 0;
  int   checks = 0;
  int   wrCount = 0;
  int   sendCount = 0;
  logic prevSend = 1'b0;
  logic [7:0] lastAddr = 8'h00;
  logic [7:0] lastWrData = 8'h00;
  logic [7:0] lastTx = 8'h00;

  uart_cmd_responder_if bus ();

  uart_cmd_responder #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .ipClk   (clk),
    .ipReset (rst),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for 5 cycles after each send request
  always @(negedge clk) begin
    if (modelBusyCnt != 0) modelBusyCnt <= modelBusyCnt - 1;
    else if (bus.opTxSend) modelBusyCnt <= 5;
  end
  assign bus.ipTxBusy = autoTx ? (modelBusyCnt != 0) : manualBusy;

  // Register file model: read data follows the address one cycle later
  always @(posedge clk) bus.ipRdData <= (bus.opAddr == 8'h20) ? 8'h3C : 8'hEE;

  always @(negedge clk) begin
    if (bus.opWrEnable) begin
      wrCount    <= wrCount + 1;
      lastAddr   <= bus.opAddr;
      lastWrData <= bus.opWrData;
    end
    if (bus.opTxSend && !prevSend) begin
      sendCount <= sendCount + 1;
      lastTx    <= bus.opTxData;
    end
    prevSend <= bus.opTxSend;
  end

  task automatic checkEqual(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.ipRxData  = b;
    bus.ipRxValid = 1'b1;
    @(negedge clk);
    bus.ipRxValid = 1'b0;
    bus.ipRxData  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendPacket(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                            input logic [7:0] chk, input int gap);
    logic [7:0] pkt [5];
    pkt = '{8'h55, cmd, addr, data, chk};
    for (int i = 0; i < PktLen; i++) sendByte(pkt[i], gap);
  endtask

  task automatic waitResponse(input string tag, input int base, input logic [7:0] want);
    int n;
    n = 0;
    while (sendCount == base && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkEqual({tag, " sends"}, 32'(sendCount - base), 32'd1);
    checkEqual({tag, " byte"}, 32'(lastTx), 32'(want));
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wrBase;
    int sendBase;
    logic sawSend;
    logic stayedHigh;
    int n;

    bus.ipRxData  = 8'h00;
    bus.ipRxValid = 1'b0;
    #1;
    checkEqual("reset txSend", 32'(bus.opTxSend), 32'd0);
    checkEqual("reset txData", 32'(bus.opTxData), 32'h00);
    checkEqual("reset addr", 32'(bus.opAddr), 32'h00);
    checkEqual("reset wrData", 32'(bus.opWrData), 32'h00);
    checkEqual("reset wrEnable", 32'(bus.opWrEnable), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Write
    wrBase = wrCount; sendBase = sendCount;
    sendPacket(8'h01, 8'h10, 8'hA5, 8'hB4, 1);
    waitResponse("write", sendBase, 8'h06);
    checkEqual("write pulses", 32'(wrCount - wrBase), 32'd1);
    checkEqual("write addr", 32'(lastAddr), 32'h10);
    checkEqual("write data", 32'(lastWrData), 32'hA5);

    // Read
    wrBase = wrCount; sendBase = sendCount;
    sendPacket(8'h02, 8'h20, 8'h00, 8'h22, 1);
    waitResponse("read", sendBase, 8'h3C);
    checkEqual("read no write", 32'(wrCount - wrBase), 32'd0);
    checkEqual("read addr", 32'(bus.opAddr), 32'h20);

    // Unknown command
    wrBase = wrCount; sendBase = sendCount;
    sendPacket(8'h07, 8'h00, 8'h00, 8'h07, 1);
    waitResponse("badcmd", sendBase, 8'h15);
    checkEqual("badcmd no write", 32'(wrCount - wrBase), 32'd0);
    checkEqual("badcmd addr kept", 32'(bus.opAddr), 32'h20);

`ifdef CHECKSUM_EN
    wrBase = wrCount; sendBase = sendCount;
    sendPacket(8'h01, 8'h10, 8'hA5, 8'h00, 1);
    waitResponse("badchk", sendBase, 8'h15);
    checkEqual("badchk no write", 32'(wrCount - wrBase), 32'd0);
`endif

    // Partial packet abandoned after the inter-byte timeout
    wrBase = wrCount; sendBase = sendCount;
    sendByte(8'h55, 1);
    sendByte(8'h01, TimeoutCycles + 1);
    sendPacket(8'h01, 8'h33, 8'h5A, 8'h68, 1);
    waitResponse("timeout", sendBase, 8'h06);
    repeat (20) @(negedge clk);
    checkEqual("timeout single ack", 32'(sendCount - sendBase), 32'd1);
    checkEqual("timeout pulses", 32'(wrCount - wrBase), 32'd1);
    checkEqual("timeout addr", 32'(lastAddr), 32'h33);
    checkEqual("timeout data", 32'(lastWrData), 32'h5A);

    // Gaps just under the timeout still assemble a packet
    wrBase = wrCount; sendBase = sendCount;
    sendPacket(8'h01, 8'h5B, 8'hC3, 8'h99, int'(TimeoutCycles) - 4);
    waitResponse("slowgap", sendBase, 8'h06);
    checkEqual("slowgap pulses", 32'(wrCount - wrBase), 32'd1);
    checkEqual("slowgap addr", 32'(lastAddr), 32'h5B);

    // Transmitter busy for a long time; stray bytes meanwhile are ignored
    autoTx = 1'b0; manualBusy = 1'b1;
    wrBase = wrCount; sendBase = sendCount;
    sendPacket(8'h01, 8'h44, 8'h99, 8'hDC, 1);
    sendByte(8'h55, 1);
    sendByte(8'h02, 1);
    sawSend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.opTxSend) sawSend = 1'b1;
    end
    checkEqual("busy send low", 32'(sawSend), 32'd0);
    manualBusy = 1'b0;
    n = 0;
    while (!bus.opTxSend && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkEqual("send after idle", 32'(bus.opTxSend), 32'd1);
    checkEqual("busy tx byte", 32'(bus.opTxData), 32'h06);
    stayedHigh = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.opTxSend) stayedHigh = 1'b0;
    end
    checkEqual("send held", 32'(stayedHigh), 32'd1);
    manualBusy = 1'b1;
    repeat (3) @(negedge clk);
    checkEqual("send released", 32'(bus.opTxSend), 32'd0);
    manualBusy = 1'b0;
    repeat (10) @(negedge clk);
    checkEqual("busy pulses", 32'(wrCount - wrBase), 32'd1);
    checkEqual("busy addr", 32'(lastAddr), 32'h44);
    checkEqual("busy sends", 32'(sendCount - sendBase), 32'd1);

    // Reset while the send request is asserted
    sendPacket(8'h01, 8'h77, 8'h12, 8'h64, 1);
    n = 0;
    while (!bus.opTxSend && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkEqual("txassert reached", 32'(bus.opTxSend), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkEqual("async rst txSend", 32'(bus.opTxSend), 32'd0);
    checkEqual("async rst txData", 32'(bus.opTxData), 32'h00);
    checkEqual("async rst addr", 32'(bus.opAddr), 32'h00);
    checkEqual("async rst wrData", 32'(bus.opWrData), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    autoTx = 1'b1;
    repeat (10) @(negedge clk);
    wrBase = wrCount; sendBase = sendCount;
    sendPacket(8'h01, 8'h21, 8'h42, 8'h62, 1);
    waitResponse("postrst", sendBase, 8'h06);
    checkEqual("postrst pulses", 32'(wrCount - wrBase), 32'd1);
    checkEqual("postrst addr", 32'(lastAddr), 32'h21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
